// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - camera byte stream to 2:1 decimated RGB565 frame-buffer writer
module frame_writer #(
   parameter int SRC_W = 320,
   parameter int SRC_H = 240
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        vsync,
   input  logic        href,
   input  logic [7:0]  data,
   output logic        we,
   output logic [16:0] wAddr,
   output logic [15:0] wData,
   output logic        frame_done,
   output logic        busy
);

   localparam int COL_W  = $clog2(SRC_W + 1);
   localparam int ROW_W  = $clog2(SRC_H + 1);
   localparam int HALF_W = SRC_W / 2;

   typedef enum logic [1:0] {S_IDLE, S_SYNC, S_FRAME} state_t;

   state_t           state;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             phase;
   logic [7:0]       hi_byte;
   logic             vsync_q;
   logic             href_q;

   logic [16:0]      addr_calc;
   logic             store_ok;
   logic             vsync_rise;

   always_comb begin
      addr_calc  = 17'(HALF_W) * 17'(row >> 1) + 17'(col >> 1);
      store_ok   = !col[0] && !row[0] && (int'(col) < SRC_W) && (int'(row) < SRC_H);
      vsync_rise = vsync && !vsync_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         col        <= '0;
         row        <= '0;
         phase      <= 1'b0;
         hi_byte    <= '0;
         vsync_q    <= 1'b0;
         href_q     <= 1'b0;
         we         <= 1'b0;
         wAddr      <= '0;
         wData      <= '0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         vsync_q    <= vsync;
         href_q     <= href;
         we         <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (vsync) state <= S_SYNC;
            end
            S_SYNC: begin
               if (!vsync) begin
                  state <= S_FRAME;
                  busy  <= 1'b1;
                  row   <= '0;
                  col   <= '0;
                  phase <= 1'b0;
               end
            end
            S_FRAME: begin
               // A vsync rise wins over any byte on the same cycle: the in-flight pixel is dropped.
               if (vsync_rise) begin
                  state      <= S_SYNC;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                  phase      <= 1'b0;
               end else if (href) begin
                  if (!phase) begin
                     hi_byte <= data;
                     phase   <= 1'b1;
                  end else begin
                     phase <= 1'b0;
                     if (int'(col) < SRC_W) col <= col + 1'b1;
                     if (store_ok) begin
                        we    <= 1'b1;
                        wAddr <= addr_calc;
                        wData <= {hi_byte, data};
                     end
                  end
               end else if (href_q) begin
                  col   <= '0;
                  phase <= 1'b0;
                  if (int'(row) < SRC_H) row <= row + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_writer.sv
// tb/tb_frame_writer.sv - scoreboard bench for frame_writer
module tb_frame_writer;

   localparam int W   = 320;
   localparam int H   = 16;
   localparam int GAP = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        vsync;
   logic        href;
   logic [7:0]  data;
   logic        we;
   logic [16:0] wAddr;
   logic [15:0] wData;
   logic        frame_done;
   logic        busy;

   frame_writer #(.SRC_W(W), .SRC_H(H)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .vsync      (vsync),
      .href       (href),
      .data       (data),
      .we         (we),
      .wAddr      (wAddr),
      .wData      (wData),
      .frame_done (frame_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [16:0] addr;
      logic [15:0] pix;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc        = 0;
   int   n_checks   = 0;
   int   n_err      = 0;
   int   wr_count   = 0;
   int   fd_count   = 0;
   int   fd_exp_cyc = 0;
   logic [16:0] last_addr = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset_n && we) begin
         wr_count++;
         last_addr = wAddr;
         if (sb.size() == 0) begin
            check("unexpected_write", {15'd0, wAddr}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("waddr", {15'd0, wAddr}, {15'd0, e.addr});
            check("wdata", {16'd0, wData}, {16'd0, e.pix});
            check("write_cycle", cyc, e.cyc);
         end
      end
      if (reset_n && frame_done) begin
         fd_count++;
         check("frame_done_cycle", cyc, fd_exp_cyc);
      end
   end

   task automatic tick(input logic v, input logic h, input logic [7:0] d);
      @(posedge clk);
      #1;
      vsync = v;
      href  = h;
      data  = d;
   endtask

   task automatic send_line(input int npix, input int extra, input bit cap, input int row, input bit seq);
      logic [15:0] pix;
      for (int p = 0; p < npix; p++) begin
         pix = seq ? 16'(p) : 16'($urandom);
         tick(1'b0, 1'b1, pix[15:8]);
         tick(1'b0, 1'b1, pix[7:0]);
         if (cap && row % 2 == 0 && p % 2 == 0 && p < W && row < H)
            sb.push_back('{addr: 17'((W / 2) * (row / 2) + p / 2), pix: pix, cyc: cyc + 1});
      end
      for (int i = 0; i < extra; i++) tick(1'b0, 1'b1, 8'($urandom));
      repeat (GAP) tick(1'b0, 1'b0, 8'h00);
   endtask

   task automatic start_frame(input string tag);
      repeat (3) tick(1'b1, 1'b0, 8'h00);
      repeat (3) tick(1'b0, 1'b0, 8'h00);
      check({tag, "_busy_on"}, {31'd0, busy}, 32'd1);
   endtask

   task automatic end_frame(input string tag);
      int fd0;
      fd0 = fd_count;
      tick(1'b1, 1'b0, 8'h00);
      fd_exp_cyc = cyc + 1;
      repeat (6) tick(1'b1, 1'b0, 8'h00);
      check({tag, "_frame_done_pulses"}, fd_count - fd0, 32'd1);
      check({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
      check({tag, "_sb_drained"}, sb.size(), 32'd0);
   endtask

   initial begin
      int wr0;
      int fd0;
      logic [15:0] pix;
      reset_n = 1'b0;
      vsync   = 1'b0;
      href    = 1'b0;
      data    = 8'h00;
      #12;
      check("rst_we", {31'd0, we}, 32'd0);
      check("rst_waddr", {15'd0, wAddr}, 32'd0);
      check("rst_wdata", {16'd0, wData}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      tick(1'b0, 1'b0, 8'h00);
      reset_n = 1'b1;

      // full frame with two rows beyond the stored height
      wr0 = wr_count;
      start_frame("A");
      for (int r = 0; r < H + 2; r++) send_line(W, 0, 1'b1, r, r == 0);
      end_frame("A");
      check("A_writes", wr_count - wr0, (W / 2) * (H / 2));
      check("A_last_addr", {15'd0, last_addr}, (W / 2) * (H / 2) - 1);
      check("A_waddr_hold", {15'd0, wAddr}, (W / 2) * (H / 2) - 1);

      // over-long line: 322 pixels plus a dangling byte
      wr0 = wr_count;
      start_frame("B");
      send_line(W + 2, 1, 1'b1, 0, 1'b0);
      send_line(W, 0, 1'b1, 1, 1'b0);
      send_line(W, 0, 1'b1, 2, 1'b0);
      end_frame("B");
      check("B_writes", wr_count - wr0, W);

      // vsync rises mid-line at col 100 of row 10
      wr0 = wr_count;
      fd0 = fd_count;
      start_frame("C");
      for (int r = 0; r < 10; r++) send_line(W, 0, 1'b1, r, 1'b0);
      for (int p = 0; p < 100; p++) begin
         pix = 16'($urandom);
         tick(1'b0, 1'b1, pix[15:8]);
         tick(1'b0, 1'b1, pix[7:0]);
         if (p % 2 == 0) sb.push_back('{addr: 17'((W / 2) * 5 + p / 2), pix: pix, cyc: cyc + 1});
      end
      tick(1'b0, 1'b1, 8'hA5);
      tick(1'b1, 1'b1, 8'h5A);
      fd_exp_cyc = cyc + 1;
      repeat (10) tick(1'b1, 1'b1, 8'($urandom));
      repeat (4) tick(1'b1, 1'b0, 8'h00);
      check("C_frame_done_pulses", fd_count - fd0, 32'd1);
      check("C_busy_off", {31'd0, busy}, 32'd0);
      check("C_writes", wr_count - wr0, 5 * (W / 2) + 50);
      check("C_sb_drained", sb.size(), 32'd0);

      start_frame("D");
      send_line(W, 0, 1'b1, 0, 1'b1);
      end_frame("D");

      // reset asserted mid-frame at row 8 with a write in progress
      fd0 = fd_count;
      start_frame("E");
      for (int r = 0; r < 8; r++) send_line(W, 0, 1'b1, r, 1'b0);
      for (int p = 0; p < 50; p++) begin
         pix = 16'($urandom);
         tick(1'b0, 1'b1, pix[15:8]);
         tick(1'b0, 1'b1, pix[7:0]);
         if (p % 2 == 0) sb.push_back('{addr: 17'((W / 2) * 4 + p / 2), pix: pix, cyc: cyc + 1});
      end
      tick(1'b0, 1'b1, 8'hC3);
      tick(1'b0, 1'b1, 8'h3C);
      @(posedge clk);
      #2;
      check("E_we_before_reset", {31'd0, we}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("E_async_we", {31'd0, we}, 32'd0);
      check("E_async_waddr", {15'd0, wAddr}, 32'd0);
      check("E_async_wdata", {16'd0, wData}, 32'd0);
      check("E_async_busy", {31'd0, busy}, 32'd0);
      repeat (3) tick(1'b0, 1'b1, 8'h77);
      reset_n = 1'b1;
      wr0 = wr_count;
      for (int r = 0; r < 3; r++) send_line(W, 0, 1'b0, r, 1'b0);
      check("E_no_writes_after_reset", wr_count - wr0, 32'd0);
      check("E_busy_after_reset", {31'd0, busy}, 32'd0);
      check("E_no_frame_done", fd_count - fd0, 32'd0);

      wr0 = wr_count;
      start_frame("F");
      send_line(W, 0, 1'b1, 0, 1'b1);
      end_frame("F");
      check("F_writes", wr_count - wr0, W / 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/frame_writer.md
FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 SHALL have parameter SRC_W, default 320, source active pixels per line (even).
REQ-002 SHALL have parameter SRC_H, default 240, source active lines per frame (even).
REQ-003 SHALL have clk  input  1  single clock, camera pixel clock; all logic on rising edge.
REQ-004 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have vsync  input  1  camera frame sync; high during vertical blanking.
REQ-006 SHALL have href  input  1  camera line valid; high while line bytes are presented.
REQ-007 SHALL have data  input  8  camera byte, RGB565, high byte first per pixel.
REQ-008 SHALL have we  output  1  frame-buffer write strobe, one cycle per stored pixel.
REQ-009 SHALL have wAddr  output  17  frame-buffer write address.
REQ-010 SHALL have wData  output  16  RGB565 pixel {rrrrr,gggggg,bbbbb}.
REQ-011 SHALL have frame_done  output  1  one-cycle pulse at end of each captured frame.
REQ-012 SHALL have busy  output  1  high while state is S_FRAME.

Function
REQ-013 SHALL implement states S_IDLE, S_SYNC, S_FRAME.
REQ-014 S_IDLE SHALL move to S_SYNC on a cycle with vsync=1 (a partial frame after reset is never stored).
REQ-015 S_SYNC SHALL move to S_FRAME on a cycle with vsync=0, clearing row, col, byte phase.
REQ-016 S_FRAME SHALL move to S_SYNC on a vsync rising edge (vsync=1, previous-cycle vsync=0).
REQ-017 In S_FRAME with href=1, bytes SHALL alternate: phase 0 latches high byte, phase 1 completes a pixel.
REQ-018 On pixel completion col SHALL increment by 1 and phase SHALL return to 0.
REQ-019 On an href falling edge in S_FRAME, row SHALL increment by 1, col and phase SHALL clear.
REQ-020 An unpaired high byte at href fall SHALL be discarded with no write.
REQ-021 A completed pixel SHALL be written only if col and row are both even, col<SRC_W, row<SRC_H (2:1 decimation each axis).
REQ-022 wAddr SHALL equal (SRC_W/2)*(row>>1)+(col>>1), computed without truncation below 17 bits; default range 0..19199.
REQ-023 wData SHALL equal {high byte, low byte} of the written pixel.
REQ-024 we, wAddr, wData SHALL be registered: asserted the cycle after the edge sampling the low byte.
REQ-025 we SHALL be high for exactly one cycle per write; wAddr/wData SHALL hold between writes.
REQ-026 Pixels with col>=SRC_W or rows with row>=SRC_H SHALL be dropped; counters SHALL saturate, not wrap.
REQ-027 frame_done SHALL pulse one cycle, the cycle after the S_FRAME->S_SYNC transition edge, including mid-line aborts.
REQ-028 vsync rising mid-line SHALL abort the line: in-flight partial pixel discarded, no further writes.
REQ-029 href SHALL be ignored in S_IDLE and S_SYNC.

Reset
REQ-030 reset_n low SHALL immediately force state S_IDLE; we=0, wAddr=0, wData=0, frame_done=0, busy=0.
REQ-031 Reset SHALL clear row, col, phase, latched byte, and vsync/href history registers to 0.
REQ-032 Reset asserted mid-frame SHALL suppress all writes until a full vsync high->low sequence follows release.

Verification
REQ-033 Reset, vsync 1->0, one 320-pixel line with pixel n = 16'h0000+n -> 160 writes, wAddr 0..159, wData 0,2,4..318, one cycle after each low byte.
REQ-034 Full 320x240 frame then vsync rise -> exactly 19200 writes, last wAddr 19199, frame_done single pulse, busy falls.
REQ-035 Release reset with vsync=0 and lines streaming -> no writes until vsync 1 then 0; then row 0 maps to wAddr 0.
REQ-036 Line with 645 bytes (322 pixels + 1 byte) -> writes only for col 0..318 even; extra bytes ignored; next row starts col 0.
REQ-037 vsync rises at col 100 of row 50 -> no writes after it, frame_done pulses once, next frame restarts at wAddr 0.
REQ-038 reset_n pulsed low at row 120 -> outputs 0 asynchronously, no writes until next vsync high->low.
